// File: rtl/mc_cycle_counter.sv
// Multi-channel instruction cycle counter. Each channel times one instruction and
// parks the result in a pending slot; slots drain round-robin through one valid/ready output.
module mc_cycle_counter #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 0,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] instr_start,
  input  logic [NUM_CH-1:0] instr_active,
  input  logic [NUM_CH-1:0] instr_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat,
  output logic              res_timeout,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] overrun,
  input  logic              overrun_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] cap_v;
  logic [NUM_CH-1:0] cap_sat_v;
  logic [CNT_W-1:0]  cap_cnt [NUM_CH];

  // Per-channel measurement engines
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             sat_q, sat_d;
    logic             cap_l, cap_sat_l;
    logic [CNT_W-1:0] cap_cnt_l;

    always_comb begin
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      sat_d     = sat_q;
      cap_l     = 1'b0;
      cap_cnt_l = cnt_q;
      cap_sat_l = sat_q;
      if (instr_start[gi]) begin
        cnt_d  = CNT_W'(1);
        sat_d  = 1'b0;
        busy_d = !instr_done[gi];
        if (instr_done[gi]) begin
          cap_l     = 1'b1;
          cap_cnt_l = CNT_W'(1);
          cap_sat_l = 1'b0;
        end
      end else if (busy_q) begin
        if (instr_done[gi]) begin
          cap_l  = 1'b1;
          busy_d = 1'b0;
        end else if (instr_active[gi]) begin
          if (cnt_q == CNT_MAX) sat_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
        sat_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        busy_q <= busy_d;
        sat_q  <= sat_d;
      end
    end

    assign cap_v[gi]     = cap_l;
    assign cap_sat_v[gi] = cap_sat_l;
    assign cap_cnt[gi]   = cap_cnt_l;
    assign busy[gi]      = busy_q;
  end

  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [NUM_CH-1:0] slot_sat_q, slot_sat_d;
  logic [NUM_CH-1:0] slot_to_q, slot_to_d;
  logic [CNT_W-1:0]  slot_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  slot_cnt_d [NUM_CH];
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              res_valid_q, res_valid_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic [CNT_W-1:0]  res_count_q, res_count_d;
  logic              res_sat_q, res_sat_d;
  logic              res_to_q, res_to_d;

  logic              load_en;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   cand;
  logic [NUM_CH-1:0] unload_vec;

  assign load_en = !res_valid_q || res_ready;

  // Round-robin search starts one past the last granted channel
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    unload_vec = '0;
    if (load_en && grant_found) unload_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    slot_sat_d = slot_sat_q;
    slot_to_d  = slot_to_q;
    slot_cnt_d = slot_cnt_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      // A fresh capture wins over a same-cycle unload, so pending stays set
      pending_d[ch] = (pending_q[ch] && !unload_vec[ch]) || cap_v[ch];
      overrun_d[ch] = (cap_v[ch] && pending_q[ch] && !unload_vec[ch]) ||
                      (overrun_q[ch] && !overrun_clr);
      if (cap_v[ch]) begin
        slot_cnt_d[ch] = cap_cnt[ch];
        slot_sat_d[ch] = cap_sat_v[ch];
        slot_to_d[ch]  = (TIMEOUT_CYC != 0) && (64'(cap_cnt[ch]) >= 64'(TIMEOUT_CYC));
      end
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_count_d = res_count_q;
    res_sat_d   = res_sat_q;
    res_to_d    = res_to_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      res_valid_d = grant_found;
      if (grant_found) begin
        res_ch_d    = grant_idx;
        res_count_d = slot_cnt_q[grant_idx];
        res_sat_d   = slot_sat_q[grant_idx];
        res_to_d    = slot_to_q[grant_idx];
        ptr_d       = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      overrun_q   <= '0;
      slot_sat_q  <= '0;
      slot_to_q   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) slot_cnt_q[ch] <= '0;
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_count_q <= '0;
      res_sat_q   <= 1'b0;
      res_to_q    <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      slot_sat_q  <= slot_sat_d;
      slot_to_q   <= slot_to_d;
      slot_cnt_q  <= slot_cnt_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_count_q <= res_count_d;
      res_sat_q   <= res_sat_d;
      res_to_q    <= res_to_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_count   = res_count_q;
  assign res_sat     = res_sat_q;
  assign res_timeout = res_to_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_mc_cycle_counter.sv
// Directed bench for mc_cycle_counter (4 channels, 8-bit counters, timeout at 100).
module tb_mc_cycle_counter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] instr_start = '0;
  logic [NUM_CH-1:0] instr_active = '0;
  logic [NUM_CH-1:0] instr_done = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [CH_W-1:0]   res_ch;
  logic [CNT_W-1:0]  res_count;
  logic              res_sat;
  logic              res_timeout;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] overrun;
  logic              overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  mc_cycle_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst),
    .instr_start(instr_start), .instr_active(instr_active), .instr_done(instr_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_count(res_count), .res_sat(res_sat), .res_timeout(res_timeout),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int ch, input int cnt, input int sat, input int to);
    chk({tag, ".valid"},   64'(res_valid),   64'd1);
    chk({tag, ".ch"},      64'(res_ch),      64'(ch));
    chk({tag, ".count"},   64'(res_count),   64'(cnt));
    chk({tag, ".sat"},     64'(res_sat),     64'(sat));
    chk({tag, ".timeout"}, 64'(res_timeout), 64'(to));
    $display("result %s: ch=%0d count=%0d sat=%0d timeout=%0d", tag, res_ch, res_count, res_sat, res_timeout);
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst.valid", 64'(res_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    res_ready = 1'b1;
    tick();

    // Ch0: start, 4 active cycles, done -> count 5
    instr_start = 4'b0001; tick(); instr_start = '0;
    chk("t1.busy", 64'(busy), 64'b0001);
    instr_active = 4'b0001; tick(4); instr_active = '0;
    instr_done = 4'b0001; tick(); instr_done = '0;
    chk("t1.latency", 64'(res_valid), 64'd0);
    chk("t1.busy_clr", 64'(busy), 64'd0);
    tick();
    chk_res("t1", 0, 5, 0, 0);
    tick();
    chk("t1.drain", 64'(res_valid), 64'd0);

    // Ch1 (count 3) and ch2 (count 6) done together -> ch1 then ch2
    instr_start = 4'b0110; tick(); instr_start = '0;
    instr_active = 4'b0110; tick(2);
    instr_active = 4'b0100; tick(3); instr_active = '0;
    instr_done = 4'b0110; tick(); instr_done = '0;
    tick();
    chk_res("t2a", 1, 3, 0, 0);
    tick();
    chk_res("t2b", 2, 6, 0, 0);
    tick();
    chk("t2.drain", 64'(res_valid), 64'd0);

    // Start+done same cycle on ch3 -> count 1; lone done on ch0 ignored
    instr_start = 4'b1000; instr_done = 4'b1000; tick();
    instr_start = '0; instr_done = '0;
    tick();
    chk_res("t3", 3, 1, 0, 0);
    tick();
    chk("t3.drain", 64'(res_valid), 64'd0);
    instr_done = 4'b0001; tick(); instr_done = '0;
    tick(2);
    chk("t3.stray_done", 64'(res_valid), 64'd0);

    // Saturation: ch0 active 300 cycles -> 255, sat, timeout
    instr_start = 4'b0001; tick(); instr_start = '0;
    instr_active = 4'b0001; tick(300); instr_active = '0;
    instr_done = 4'b0001; tick(); instr_done = '0;
    tick();
    chk_res("t4sat", 0, 255, 1, 1);
    tick();

    // Timeout boundary: ch1 = 99 (no timeout), ch2 = 100 (timeout)
    instr_start = 4'b0110; tick(); instr_start = '0;
    for (int i = 0; i < 99; i++) begin
      instr_active = (i < 98) ? 4'b0110 : 4'b0100;
      tick();
    end
    instr_active = '0;
    instr_done = 4'b0110; tick(); instr_done = '0;
    tick();
    chk_res("t4to99", 1, 99, 0, 0);
    tick();
    chk_res("t4to100", 2, 100, 0, 1);
    tick();

    // Overrun: output stalled with ch0=2, pending ch0=3 overwritten by ch0=4
    res_ready = 1'b0;
    instr_start = 4'b0001; tick(); instr_start = '0;
    instr_active = 4'b0001; tick(); instr_active = '0;
    instr_done = 4'b0001; tick(); instr_done = '0;
    tick();
    chk_res("t5first", 0, 2, 0, 0);
    instr_start = 4'b0001; tick(); instr_start = '0;
    instr_active = 4'b0001; tick(2); instr_active = '0;
    instr_done = 4'b0001; tick(); instr_done = '0;
    chk("t5.no_overrun", 64'(overrun), 64'd0);
    instr_start = 4'b0001; tick(); instr_start = '0;
    instr_active = 4'b0001; tick(3); instr_active = '0;
    instr_done = 4'b0001; tick(); instr_done = '0;
    chk("t5.overrun", 64'(overrun), 64'b0001);
    chk_res("t5hold", 0, 2, 0, 0);
    res_ready = 1'b1; tick();
    chk_res("t5second", 0, 4, 0, 0);
    tick();
    chk("t5.drain", 64'(res_valid), 64'd0);
    chk("t5.sticky", 64'(overrun), 64'b0001);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("t5.clr", 64'(overrun), 64'd0);

    // Reset while ch3 busy and a ch1 result is stalled
    res_ready = 1'b0;
    instr_start = 4'b0010; instr_done = 4'b0010; tick();
    instr_start = '0; instr_done = '0;
    tick();
    chk_res("t6stall", 1, 1, 0, 0);
    instr_start = 4'b1000; tick(); instr_start = '0;
    instr_active = 4'b1000; tick(2);
    chk("t6.busy", 64'(busy), 64'b1000);
    rst = 1'b1; #1;
    chk("t6.rst_valid", 64'(res_valid), 64'd0);
    chk("t6.rst_count", 64'(res_count), 64'd0);
    chk("t6.rst_ch", 64'(res_ch), 64'd0);
    chk("t6.rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    tick(2);
    instr_done = 4'b1000; tick(); instr_done = '0;
    instr_active = '0;
    res_ready = 1'b1;
    tick(3);
    chk("t6.no_result", 64'(res_valid), 64'd0);
    chk("t6.busy_after", 64'(busy), 64'd0);
    instr_start = 4'b0100; tick(); instr_start = '0;
    instr_done = 4'b0100; tick(); instr_done = '0;
    tick();
    chk_res("t6new", 2, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_cycle_counter.md
MC_CYCLE_COUNTER -- requirements
Module: mc_cycle_counter

Interface
REQ-001 The block SHALL have the parameter NUM_CH, default 4, meaning the number of independent instruction-timing channels (1..16).
REQ-002 The block SHALL have the parameter CNT_W, default 32, meaning the counter and result width in bits (8..32).
REQ-003 The block SHALL have the parameter TIMEOUT_CYC, default 0, meaning the timeout threshold in cycles; 0 disables the timeout flag.
REQ-004 The block SHALL derive CH_W = max(1, clog2(NUM_CH)).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 instr_start  in  NUM_CH  per-channel pulse: an instruction is starting.
REQ-009 instr_active  in  NUM_CH  per-channel level: the instruction is executing.
REQ-010 instr_done  in  NUM_CH  per-channel pulse: the instruction has completed.
REQ-011 res_valid  out  1  a result is presented.
REQ-012 res_ready  in  1  the consumer accepts the result.
REQ-013 res_ch  out  CH_W  channel index of the presented result.
REQ-014 res_count  out  CNT_W  measured cycle count.
REQ-015 res_sat  out  1  the count saturated.
REQ-016 res_timeout  out  1  count >= TIMEOUT_CYC (only when TIMEOUT_CYC != 0).
REQ-017 busy  out  NUM_CH  the channel is currently counting.
REQ-018 overrun  out  NUM_CH  sticky: an unconsumed result on this channel was overwritten.
REQ-019 overrun_clr  in  1  synchronous clear of all overrun bits.

Function
REQ-020 Per-channel counting SHALL work as follows: instr_start loads the counter with 1 and sets busy; otherwise, when busy and instr_active, the counter increments.
REQ-021 The counter SHALL saturate at 2^CNT_W-1, hold that value, and set a per-channel sat bit; the sat bit is cleared by instr_start.
REQ-022 When instr_done is asserted while busy, the channel SHALL capture the current counter value (the pre-increment value) and the sat bit into its pending slot, set pending, and clear busy.
REQ-023 When instr_start and instr_done are asserted in the same cycle, the channel SHALL capture count 1, sat 0, and end with busy 0.
REQ-024 instr_done asserted while not busy (and without a coincident start) SHALL be ignored.
REQ-025 instr_start asserted while busy SHALL restart the measurement, discard the old measurement, and produce no result.
REQ-026 A capture into an already-pending slot that is not being unloaded in the same cycle SHALL overwrite the slot and set overrun[ch].
REQ-027 A capture in the same cycle as its own slot's unload SHALL keep pending set with the new data and SHALL NOT set overrun.
REQ-028 An overrun set event SHALL take priority over overrun_clr in the same cycle.
REQ-029 Output arbitration SHALL be round-robin over the pending slots, starting at the channel after the last one granted.
REQ-030 A slot SHALL be loaded into the output register when res_valid is 0, or when res_valid and res_ready are both 1 in that cycle; the granted slot's pending bit is cleared.
REQ-031 res_valid, res_ch, res_count, res_sat and res_timeout SHALL hold stable while res_valid=1 and res_ready=0.
REQ-032 Latency: instr_done sampled at edge k SHALL give pending at k and earliest res_valid=1 after edge k+1, for an idle output and no competing channels.
REQ-033 Throughput SHALL be one result per cycle when res_ready is held at 1.
REQ-034 res_timeout SHALL be computed from the captured count at capture time.

Reset
REQ-035 While rst=1, all counters, busy, pending, sat, overrun, res_valid, res_ch, res_count, res_sat, res_timeout and the round-robin pointer SHALL be 0.
REQ-036 Asserting rst mid-measurement or mid-handshake SHALL abort without emitting any result.
REQ-037 After rst deasserts, a result SHALL appear only from a new instr_start/instr_done sequence.

Verification
REQ-038 Ch0: start, active for 4 cycles, done -> single result with res_ch=0, res_count=5, res_sat=0.
REQ-039 Ch1 and ch2 done in the same cycle with res_ready=1 -> results in round-robin order on consecutive cycles; res_valid is then 0.
REQ-040 CNT_W=8, active for 300 cycles -> res_count=255, res_sat=1; with TIMEOUT_CYC=100 -> res_timeout=1.
REQ-041 res_ready=0, ch0 completes twice -> overrun[0]=1; res_count shows the first result unchanged; after ready, the second value is delivered; overrun_clr -> overrun=0.
REQ-042 start+done in the same cycle -> res_count=1; done with no start -> no result.
REQ-043 rst pulsed while ch3 is busy and a result is stalled -> all outputs 0 immediately; no result afterwards until a new sequence.
